// File: rtl/booth_r4_controller.sv
// booth_r4_controller: sequencing FSM for a radix-4 Booth sum-and-shift multiplier
module booth_r4_controller #(
  parameter int size = 8,
  parameter int CW = $clog2(size/2)+1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    booth_bits,
  output logic          load_operands,
  output logic          adder_enable,
  output logic [1:0]    operational_mode,
  output logic          load_hi,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);
  typedef enum logic [2:0] {IDLE, LOAD, EVAL, SHIFT, DONE} state_t;
  state_t state, next;
  logic last, eval, active;
  assign last = count == CW'(size/2-1);
  assign eval = state == EVAL;
  assign active = eval && booth_bits != 3'b000 && booth_bits != 3'b111;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next;
      count <= state == LOAD ? '0 : state == SHIFT ? count + CW'(1) : count;
    end
  always_comb begin
    next = state == IDLE ? (start ? LOAD : IDLE) :
           state == LOAD ? EVAL :
           state == EVAL ? SHIFT :
           state == SHIFT ? (last ? DONE : EVAL) : IDLE;
    load_operands = state == LOAD;
    adder_enable = active;
    load_hi = active;
    operational_mode = eval ? {booth_bits == 3'b011 || booth_bits == 3'b100,
                               booth_bits[2] && booth_bits != 3'b111} : 2'b00;
    shift = state == SHIFT;
    busy = state == LOAD || state == EVAL || state == SHIFT;
    done = state == DONE;
  end
endmodule

// File: tb/tb_booth_r4_controller.sv
// tb_booth_r4_controller: directed self-checking bench for booth_r4_controller
module tb_booth_r4_controller;
  logic clk = 0, reset = 0, start = 0;
  logic [2:0] booth_bits = 3'b000;
  logic load_operands, adder_enable, load_hi, shift, busy, done;
  logic [1:0] operational_mode;
  logic [2:0] count;
  logic [10:0] obs;
  int vecs = 0, errs = 0;
  booth_r4_controller dut (
    .clk(clk), .reset(reset), .start(start), .booth_bits(booth_bits),
    .load_operands(load_operands), .adder_enable(adder_enable),
    .operational_mode(operational_mode), .load_hi(load_hi), .shift(shift),
    .busy(busy), .done(done), .count(count)
  );
  assign obs = {load_operands, adder_enable, operational_mode, load_hi, shift, busy, done, count};
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 0;
    start = 1;
    repeat (2) begin
      step;
      #1;
      vecs++;
      if (obs !== 11'b0) begin errs++; $display("FAIL reset_hold: got %b want %b", obs, 11'b0); end
    end
    reset = 1;
    step;
    #1;
    vecs++;
    if (obs !== 11'b1_0_00_0_0_1_0_000) begin errs++; $display("FAIL reset_release_load: got %b want %b", obs, 11'b1_0_00_0_0_1_0_000); end
    reset = 0;
    start = 0;
    step;
    #1;
    vecs++;
    if (obs !== 11'b0) begin errs++; $display("FAIL reset_reapply: got %b want %b", obs, 11'b0); end
    reset = 1;
  endtask
  task automatic test_mult;
    logic [10:0] exp [11];
    logic [2:0] bs [4];
    bs = '{3'b001, 3'b011, 3'b100, 3'b110};
    exp = '{11'b1_0_00_0_0_1_0_000, 11'b0_1_00_1_0_1_0_000, 11'b0_0_00_0_1_1_0_000,
            11'b0_1_10_1_0_1_0_001, 11'b0_0_00_0_1_1_0_001, 11'b0_1_11_1_0_1_0_010,
            11'b0_0_00_0_1_1_0_010, 11'b0_1_01_1_0_1_0_011, 11'b0_0_00_0_1_1_0_011,
            11'b0_0_00_0_0_0_1_100, 11'b0_0_00_0_0_0_0_100};
    start = 1;
    for (int c = 1; c <= 11; c++) begin
      step;
      start = 0;
      if (c inside {2, 4, 6, 8}) booth_bits = bs[(c-2)/2];
      #1;
      vecs++;
      if (obs !== exp[c-1]) begin errs++; $display("FAIL mult c%0d: got %b want %b", c, obs, exp[c-1]); end
    end
  endtask
  task automatic test_noop;
    logic [10:0] exp [11];
    logic [2:0] bs [4];
    bs = '{3'b000, 3'b111, 3'b010, 3'b101};
    exp = '{11'b1_0_00_0_0_1_0_100, 11'b0_0_00_0_0_1_0_000, 11'b0_0_00_0_1_1_0_000,
            11'b0_0_00_0_0_1_0_001, 11'b0_0_00_0_1_1_0_001, 11'b0_1_00_1_0_1_0_010,
            11'b0_0_00_0_1_1_0_010, 11'b0_1_01_1_0_1_0_011, 11'b0_0_00_0_1_1_0_011,
            11'b0_0_00_0_0_0_1_100, 11'b0_0_00_0_0_0_0_100};
    start = 1;
    for (int c = 1; c <= 11; c++) begin
      step;
      start = 0;
      if (c inside {2, 4, 6, 8}) booth_bits = bs[(c-2)/2];
      #1;
      vecs++;
      if (obs !== exp[c-1]) begin errs++; $display("FAIL noop c%0d: got %b want %b", c, obs, exp[c-1]); end
    end
  endtask
  task automatic test_start_ignored;
    logic [10:0] exp [12];
    logic [2:0] bs [4];
    bs = '{3'b010, 3'b011, 3'b100, 3'b111};
    exp = '{11'b1_0_00_0_0_1_0_100, 11'b0_1_00_1_0_1_0_000, 11'b0_0_00_0_1_1_0_000,
            11'b0_1_10_1_0_1_0_001, 11'b0_0_00_0_1_1_0_001, 11'b0_1_11_1_0_1_0_010,
            11'b0_0_00_0_1_1_0_010, 11'b0_0_00_0_0_1_0_011, 11'b0_0_00_0_1_1_0_011,
            11'b0_0_00_0_0_0_1_100, 11'b0_0_00_0_0_0_0_100, 11'b0_0_00_0_0_0_0_100};
    start = 1;
    for (int c = 1; c <= 12; c++) begin
      step;
      start = c >= 2 && c <= 9;
      if (c inside {2, 4, 6, 8}) booth_bits = bs[(c-2)/2];
      #1;
      vecs++;
      if (obs !== exp[c-1]) begin errs++; $display("FAIL start_ignored c%0d: got %b want %b", c, obs, exp[c-1]); end
    end
  endtask
  task automatic test_abort;
    logic [10:0] exp [12];
    exp = '{11'b1_0_00_0_0_1_0_100, 11'b0_1_00_1_0_1_0_000, 11'b0_0_00_0_1_1_0_000,
            11'b0_1_00_1_0_1_0_001, 11'b0_0_00_0_1_1_0_001, 11'b0, 11'b0, 11'b0,
            11'b0, 11'b0, 11'b0, 11'b0};
    booth_bits = 3'b001;
    start = 1;
    for (int c = 1; c <= 12; c++) begin
      step;
      start = 0;
      reset = c != 5;
      #1;
      vecs++;
      if (obs !== exp[c-1]) begin errs++; $display("FAIL abort c%0d: got %b want %b", c, obs, exp[c-1]); end
    end
  endtask
  task automatic test_back_to_back;
    booth_bits = 3'b000;
    start = 1;
    for (int c = 1; c <= 33; c++) begin
      int m;
      m = (c-1) % 11;
      step;
      #1;
      vecs++;
      if ({load_operands, busy, done} !== {m == 0, m <= 8, m == 9}) begin
        errs++;
        $display("FAIL back_to_back c%0d: got ld/busy/done %b want %b", c, {load_operands, busy, done}, {m == 0, m <= 8, m == 9});
      end
    end
    start = 0;
  endtask
  initial begin
    test_reset;
    test_mult;
    test_noop;
    test_start_ignored;
    test_abort;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
